jpeg_bit_packer: RTL and testbench

//  Downstream of the ones-complement (VLI) encoder and Huffman lookup.
//  - Accepts variable-length code words (Huffman code and/or VLI value, up to MAX_LEN bits).
//  - Packs them MSB-first into a byte stream.
//  - On flush, pads the final partial byte with 1s and flags the last byte.
//  - Feeds the entropy-coded segment writer.

---
 rtl/jpeg_bit_packer_if.sv | 26 ++
 rtl/jpeg_bit_packer.sv | 150 +++++++++++++++
 tb/tb_jpeg_bit_packer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_bit_packer_if.sv
// rtl/jpeg_bit_packer_if.sv - code-word input and byte output handshake bundle for jpeg_bit_packer
interface jpeg_bit_packer_if #(
  parameter int MAX_LEN = 27
) ();
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               in_valid;
  logic               in_ready;
  logic [MAX_LEN-1:0] in_bits;
  logic [LEN_W-1:0]   in_len;
  logic               in_flush;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_byte;
  logic               out_last;

  modport master (
    output in_valid, in_bits, in_len, in_flush, out_ready,
    input  in_ready, out_valid, out_byte, out_last
  );

  modport slave (
    input  in_valid, in_bits, in_len, in_flush, out_ready,
    output in_ready, out_valid, out_byte, out_last
  );
endinterface

// File: rtl/jpeg_bit_packer.sv
// rtl/jpeg_bit_packer.sv - MSB-first code-word to byte packer with 1-padded flush; JPEG_BYTE_STUFF_EN adds 0x00 after each 0xFF
module jpeg_bit_packer #(
  parameter int MAX_LEN = 27
) (
  input logic              clk,
  input logic              rst_n,
  jpeg_bit_packer_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int BUF_W = MAX_LEN + 7;
  localparam int CNT_W = $clog2(BUF_W + 1);

`ifdef JPEG_BYTE_STUFF_EN
  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_LAST, S_STUFF} state_t;
`else
  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_LAST} state_t;
`endif

  state_t           r_state;
  logic [BUF_W-1:0] r_buf;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  logic [7:0]       r_out_byte;
  logic             r_out_last;
`ifdef JPEG_BYTE_STUFF_EN
  logic             r_stuff_last;
  logic             r_stuff_flush;
`endif

  logic [LEN_W-1:0] w_len;
  logic             w_in_ready;
  logic             w_acc;
  logic             w_slot;
  logic [BUF_W-1:0] w_word;
  logic [CNT_W-1:0] w_shamt;
  logic [BUF_W-1:0] w_buf_m;
  logic [CNT_W-1:0] w_cnt_m;
  logic             w_fl;
  logic             w_can_load;
  logic             w_load_full;
  logic             w_load_pad;
  logic             w_load;
  logic             w_final;
  logic [7:0]       w_byte;

  always_comb begin
    w_len      = (bus.in_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.in_len;
    w_in_ready = (r_state == S_RUN) && (r_count < CNT_W'(8)) && !(r_out_valid && !bus.out_ready);
    w_acc      = bus.in_valid && w_in_ready;
    w_slot     = !r_out_valid || bus.out_ready;
    // New word lands directly below the bits already held; bits under r_count are always zero.
    w_word     = BUF_W'(bus.in_bits) & ((BUF_W'(1) << w_len) - BUF_W'(1));
    w_shamt    = CNT_W'(BUF_W) - r_count - CNT_W'(w_len);
    w_buf_m    = w_acc ? (r_buf | (w_word << w_shamt)) : r_buf;
    w_cnt_m    = w_acc ? (r_count + CNT_W'(w_len)) : r_count;
    w_fl       = (r_state == S_FLUSH) || (w_acc && bus.in_flush);
    w_can_load = w_slot && ((r_state == S_RUN) || (r_state == S_FLUSH));
    w_load_full = w_can_load && (w_cnt_m >= CNT_W'(8));
    w_load_pad  = w_can_load && w_fl && (w_cnt_m != '0) && (w_cnt_m < CNT_W'(8));
    w_load      = w_load_full || w_load_pad;
    w_final     = w_fl && (w_cnt_m <= CNT_W'(8));
    w_byte      = w_buf_m[BUF_W-1 -: 8];
    if (w_load_pad) begin
      w_byte = w_byte | (8'hFF >> w_cnt_m);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_byte  = r_out_byte;
  assign bus.out_last  = r_out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_buf       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_byte  <= 8'h00;
      r_out_last  <= 1'b0;
`ifdef JPEG_BYTE_STUFF_EN
      r_stuff_last  <= 1'b0;
      r_stuff_flush <= 1'b0;
`endif
    end else begin
      if (w_load_full) begin
        r_buf   <= w_buf_m << 8;
        r_count <= w_cnt_m - CNT_W'(8);
      end else if (w_load_pad) begin
        r_buf   <= '0;
        r_count <= '0;
      end else begin
        r_buf   <= w_buf_m;
        r_count <= w_cnt_m;
      end

      unique case (r_state)
        S_RUN, S_FLUSH: begin
          if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_byte  <= w_byte;
            r_out_last  <= w_final;
`ifdef JPEG_BYTE_STUFF_EN
            // A 0xFF defers any final marker to the stuffed 0x00 that follows it.
            if (w_byte == 8'hFF) begin
              r_out_last    <= 1'b0;
              r_stuff_last  <= w_final;
              r_stuff_flush <= w_fl;
              r_state       <= S_STUFF;
            end else
`endif
            if (w_final) begin
              r_state <= S_LAST;
            end else if (w_fl) begin
              r_state <= S_FLUSH;
            end
          end else begin
            if (bus.out_ready) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end
            if ((r_state == S_FLUSH) && (w_cnt_m == '0)) begin
              r_state <= S_RUN;
            end else if (w_fl) begin
              r_state <= S_FLUSH;
            end
          end
        end
        S_LAST: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_state     <= S_RUN;
          end
        end
`ifdef JPEG_BYTE_STUFF_EN
        S_STUFF: begin
          if (w_slot) begin
            r_out_valid <= 1'b1;
            r_out_byte  <= 8'h00;
            r_out_last  <= r_stuff_last;
            r_state     <= r_stuff_last ? S_LAST : (r_stuff_flush ? S_FLUSH : S_RUN);
          end
        end
`endif
        default: r_state <= S_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_jpeg_bit_packer.sv
// tb/tb_jpeg_bit_packer.sv - self-checking bench for jpeg_bit_packer against a bit-queue reference model
module tb_jpeg_bit_packer;
  localparam int MAX_LEN = 27;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jpeg_bit_packer_if #(.MAX_LEN(MAX_LEN)) bus ();
  jpeg_bit_packer #(.MAX_LEN(MAX_LEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit collect = 1'b0;
  bit rnd_rdy = 1'b0;
  logic [8:0] got[$];
  int got_cyc[$];
  logic [8:0] exp[$];
  bit bq[$];
  int seg_bits = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (collect && rst_n && bus.out_valid && bus.out_ready) begin
      got.push_back({bus.out_last, bus.out_byte});
      got_cyc.push_back(cyc);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Reference model: plain bit queue, bytes formed from its head, padding and stuffing applied at emission.
  task automatic model_emit();
    logic [7:0] b;
    for (int i = 7; i >= 0; i--) b[i] = bq.pop_front();
    exp.push_back({1'b0, b});
`ifdef JPEG_BYTE_STUFF_EN
    if (b == 8'hFF) exp.push_back(9'h000);
`endif
  endtask

  task automatic model_word(input logic [26:0] b, input int len, input bit fl);
    logic [8:0] t;
    int l;
    l = (len > MAX_LEN) ? MAX_LEN : len;
    for (int i = l - 1; i >= 0; i--) bq.push_back(b[i]);
    seg_bits += l;
    while (bq.size() >= 8) model_emit();
    if (fl) begin
      if (bq.size() > 0) begin
        while (bq.size() < 8) bq.push_back(1'b1);
        model_emit();
      end
      if (seg_bits > 0 && exp.size() > 0) begin
        t = exp.pop_back();
        t[8] = 1'b1;
        exp.push_back(t);
      end
      seg_bits = 0;
    end
  endtask

  task automatic send_word(input logic [26:0] b, input logic [4:0] len, input bit fl);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_bits  = b;
    bus.in_len   = len;
    bus.in_flush = fl;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 300);
    checks++;
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%0b after %0d cycles, required 1", bus.in_ready, n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_flush = 1'b0;
  endtask

  task automatic wait_out(input int want);
    int n;
    n = 0;
    while (got.size() < want && n < 1000) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks += 4;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    if (bus.out_byte !== 8'h00) begin errors++; $display("FAIL reset_out_byte got=%02h exp=00", bus.out_byte); end
    if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%0b exp=0", bus.out_last); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1 collect = 1'b1;
  endtask

  task automatic test_pack_flush();
    logic [8:0] e[$];
    got.delete();
    bus.out_ready = 1'b1;
    send_word(27'b101, 5'd3, 1'b0);
    send_word(27'b11111, 5'd5, 1'b0);
    send_word(27'b010, 5'd3, 1'b1);
    send_word(27'h0FF, 5'd8, 1'b0);
    send_word(27'h012, 5'd8, 1'b1);
`ifdef JPEG_BYTE_STUFF_EN
    e = '{9'h0BF, 9'h15F, 9'h0FF, 9'h000, 9'h112};
`else
    e = '{9'h0BF, 9'h15F, 9'h0FF, 9'h112};
`endif
    wait_out(e.size());
    checks += 2;
    if (got.size() != e.size()) begin errors++; $display("FAIL pack_count got=%0d exp=%0d", got.size(), e.size()); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL pack_in_ready_after got=%0b exp=1", bus.in_ready); end
    for (int i = 0; i < e.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== e[i]) begin errors++; $display("FAIL pack_byte[%0d] got=%03h exp=%03h", i, got[i], e[i]); end
    end
  endtask

  task automatic test_backpressure();
    got.delete();
    got_cyc.delete();
    bus.out_ready = 1'b0;
    send_word(27'h000ABCD, 5'd16, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks += 3;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid[%0d] got=%0b exp=1", i, bus.out_valid); end
      if (bus.out_byte !== 8'hAB) begin errors++; $display("FAIL stall_out_byte[%0d] got=%02h exp=ab", i, bus.out_byte); end
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got=%0b exp=0", i, bus.in_ready); end
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_out(2);
    checks++;
    if (got.size() != 2) begin
      errors++; $display("FAIL stall_count got=%0d exp=2", got.size());
    end else begin
      checks += 3;
      if (got[0] !== 9'h0AB) begin errors++; $display("FAIL stall_byte0 got=%03h exp=0ab", got[0]); end
      if (got[1] !== 9'h0CD) begin errors++; $display("FAIL stall_byte1 got=%03h exp=0cd", got[1]); end
      if (got_cyc[1] - got_cyc[0] != 1) begin
        errors++; $display("FAIL stall_back_to_back gap=%0d exp=1", got_cyc[1] - got_cyc[0]);
      end
    end
  endtask

  task automatic test_long_word();
    logic [8:0] e[$];
    got.delete();
    bus.out_ready = 1'b1;
    send_word(27'h7FFFFFF, 5'd27, 1'b1);
`ifdef JPEG_BYTE_STUFF_EN
    e = '{9'h0FF, 9'h000, 9'h0FF, 9'h000, 9'h0FF, 9'h000, 9'h0FF, 9'h100};
`else
    e = '{9'h0FF, 9'h0FF, 9'h0FF, 9'h1FF};
`endif
    wait_out(e.size());
    checks++;
    if (got.size() != e.size()) begin errors++; $display("FAIL long_count got=%0d exp=%0d", got.size(), e.size()); end
    for (int i = 0; i < e.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== e[i]) begin errors++; $display("FAIL long_byte[%0d] got=%03h exp=%03h", i, got[i], e[i]); end
    end
  endtask

  task automatic test_empty_flush();
    got.delete();
    send_word(27'h5A5A5A5, 5'd0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    checks += 2;
    if (got.size() != 0) begin errors++; $display("FAIL empty_flush_bytes got=%0d exp=0", got.size()); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL empty_flush_in_ready got=%0b exp=1", bus.in_ready); end
  endtask

  task automatic test_random();
    logic [26:0] b;
    int l;
    bit fl;
    got.delete();
    exp.delete();
    bq.delete();
    seg_bits = 0;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      fl = (i == 299) || ($urandom_range(0, 7) == 0);
      l = $urandom_range(0, 31);
      if (fl && l == 0) l = 1;
      b = ($urandom_range(0, 3) == 0) ? 27'h7FFFFFF : 27'($urandom);
      model_word(b, l, fl);
      send_word(b, 5'(l), fl);
    end
    @(posedge clk);
    #2;
    rnd_rdy = 1'b0;
    bus.out_ready = 1'b1;
    wait_out(exp.size());
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL random_count got=%0d exp=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL random_byte[%0d] got=%03h exp=%03h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid_flush();
    got.delete();
    bus.out_ready = 1'b0;
    send_word(27'h00ABCDE, 5'd20, 1'b1);
    @(negedge clk);
    checks += 2;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midflush_pending got=%0b exp=1", bus.out_valid); end
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midflush_in_ready got=%0b exp=0", bus.in_ready); end
    collect = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midflush_reset_valid got=%0b exp=0", bus.out_valid); end
    if (bus.out_last !== 1'b0) begin errors++; $display("FAIL midflush_reset_last got=%0b exp=0", bus.out_last); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midflush_in_ready_after got=%0b exp=1", bus.in_ready); end
    bus.out_ready = 1'b1;
    collect = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks += 2;
    if (got.size() != 0) begin errors++; $display("FAIL midflush_residual got=%0d exp=0", got.size()); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midflush_idle_valid got=%0b exp=0", bus.out_valid); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_bits   = '0;
    bus.in_len    = '0;
    bus.in_flush  = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_pack_flush();
    test_backpressure();
    test_long_word();
    test_empty_flush();
    test_random();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
